// File: rtl/my_stream_fifo_pkg.sv
// Shared constants and beat type for the stream FIFO.
// The beat keeps the end-of-packet flag alongside its payload.
package my_stream_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF    = 8;
  localparam int unsigned AFULL_TH_DEF = 6;

  typedef struct packed {
    logic                  last;
    logic [DATA_W_DEF-1:0] data;
  } beat_t;

  // Even parity over a beat, usable by integrity checkers around the FIFO.
  function automatic logic beat_parity(input beat_t b);
    return ^{b.last, b.data};
  endfunction

endpackage

// File: rtl/my_stream_fifo_mem.sv
// Storage for the stream FIFO: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the owner.
module my_stream_fifo_mem #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/my_stream_fifo.sv
// First-word-fall-through stream FIFO with packet counting and almost-full flag.
// All handshake and status outputs come straight from registers.
module my_stream_fifo
  import my_stream_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AFULL_TH = AFULL_TH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     pkt_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = DATA_W + 1;

  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_TH);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          afull_q, afull_d;

  logic          push_s;
  logic          pop_s;
  logic [BW-1:0] wbeat_s;
  logic [BW-1:0] rbeat_s;

  assign push_s  = in_valid & in_ready_q;
  assign pop_s   = out_valid_q & out_ready;
  assign wbeat_s = {in_last, in_data};

  my_stream_fifo_mem #(
    .WIDTH (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wbeat_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rbeat_s)
  );

  // Next-state for pointers, occupancy, packet count and registered flags
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A popped last and a pushed last in the same cycle cancel out
    case ({push_s & in_last, pop_s & rbeat_s[BW-1]})
      2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    out_valid_d = (level_d != {LW{1'b0}});
    in_ready_d  = (level_d != LVL_FULL);
    afull_d     = (level_d >= LVL_AFULL);
  end

  // State registers; reset empties the FIFO and leaves it ready to accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= {LW{1'b0}};
      pkt_cnt_q   <= {LW{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      afull_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_cnt_q   <= pkt_cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      afull_q     <= afull_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = rbeat_s[DATA_W-1:0];
  assign out_last    = rbeat_s[BW-1];
  assign level       = level_q;
  assign almost_full = afull_q;
  assign pkt_cnt     = pkt_cnt_q;

endmodule
